// File: rtl/store_drain_unit_if.sv
// Store-buffer, L1 data-cache and memory-bus signal bundle
// seen by the store drain unit.
interface store_drain_unit_if #(
  parameter int PHYS       = 32,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 64
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = PHYS - 2 - OFF - IDX;
  localparam int AW  = PHYS - 2;

  logic [AW-1:0]      store_address_i;
  logic [31:0]        store_data_i;
  logic [3:0]         store_bm_i;
  logic               store_io_i;
  logic               store_valid_i;
  logic               cache_done_o;
  logic               store_busy_o;
  logic               refill_busy_i;

  logic               dc_tag_rd_o;
  logic [IDX-1:0]     dc_tag_idx_o;
  logic [TAG-1:0]     dc_tag_i;
  logic               dc_tag_vld_i;
  logic               dc_wr_en_o;
  logic [IDX+OFF-1:0] dc_wr_addr_o;
  logic [31:0]        dc_wr_data_o;
  logic [3:0]         dc_wr_bm_o;

  logic               bus_req_valid_o;
  logic               bus_req_ready_i;
  logic [AW-1:0]      bus_addr_o;
  logic [31:0]        bus_data_o;
  logic [3:0]         bus_bm_o;
  logic               bus_io_o;
  logic               bus_ack_i;
  logic               bus_err_i;
  logic               store_err_o;
  logic [AW-1:0]      err_addr_o;

  modport slave (
    input  store_address_i, store_data_i, store_bm_i,
    input  store_io_i, store_valid_i, refill_busy_i,
    input  dc_tag_i, dc_tag_vld_i,
    input  bus_req_ready_i, bus_ack_i, bus_err_i,
    output cache_done_o, store_busy_o,
    output dc_tag_rd_o, dc_tag_idx_o,
    output dc_wr_en_o, dc_wr_addr_o, dc_wr_data_o, dc_wr_bm_o,
    output bus_req_valid_o, bus_addr_o, bus_data_o,
    output bus_bm_o, bus_io_o,
    output store_err_o, err_addr_o
  );

  modport master (
    output store_address_i, store_data_i, store_bm_i,
    output store_io_i, store_valid_i, refill_busy_i,
    output dc_tag_i, dc_tag_vld_i,
    output bus_req_ready_i, bus_ack_i, bus_err_i,
    input  cache_done_o, store_busy_o,
    input  dc_tag_rd_o, dc_tag_idx_o,
    input  dc_wr_en_o, dc_wr_addr_o, dc_wr_data_o, dc_wr_bm_o,
    input  bus_req_valid_o, bus_addr_o, bus_data_o,
    input  bus_bm_o, bus_io_o,
    input  store_err_o, err_addr_o
  );
endinterface

// File: rtl/store_drain_unit.sv
// Drains committed stores: write-through, no-write-allocate
// L1 update followed by a bus write and a done pulse.
module store_drain_unit #(
  parameter int PHYS       = 32,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 64
) (
  input logic               cpu_clk_i,
  input logic               cpu_rst_ni,
  store_drain_unit_if.slave sd
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int AW  = PHYS - 2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITE, BUS_REQ, BUS_WAIT, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    bm_q, bm_d;
  logic          io_q, io_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic accept;
  logic hit;
  logic in_write;

  assign accept = (state_q == IDLE) & sd.store_valid_i
                & ~sd.refill_busy_i;
  assign hit = sd.dc_tag_vld_i
             & (sd.dc_tag_i == addr_q[AW-1:OFF+IDX]);
  assign in_write = (state_q == WRITE);

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      bm_q       <= '0;
      io_q       <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bm_q       <= bm_d;
      io_q       <= io_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    bm_d       = bm_q;
    io_d       = io_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = sd.store_address_i;
          data_d  = sd.store_data_i;
          bm_d    = sd.store_bm_i;
          io_d    = sd.store_io_i;
          state_d = sd.store_io_i ? BUS_REQ : LOOKUP;
        end
      end
      LOOKUP: state_d = hit ? WRITE : BUS_REQ;
      WRITE:  state_d = BUS_REQ;
      BUS_REQ: begin
        if (sd.bus_req_ready_i) state_d = BUS_WAIT;
      end
      BUS_WAIT: begin
        // Error address becomes visible together with the error pulse.
        if (sd.bus_ack_i) begin
          err_d   = sd.bus_err_i;
          state_d = DONE;
          if (sd.bus_err_i) err_addr_d = addr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sd.store_busy_o = (state_q != IDLE);
  assign sd.cache_done_o = (state_q == DONE);
  assign sd.store_err_o  = (state_q == DONE) & err_q;
  assign sd.err_addr_o   = err_addr_q;

  assign sd.dc_tag_rd_o  = accept & ~sd.store_io_i;
  assign sd.dc_tag_idx_o = sd.dc_tag_rd_o
                         ? sd.store_address_i[OFF+IDX-1:OFF]
                         : '0;

  assign sd.dc_wr_en_o   = in_write;
  assign sd.dc_wr_addr_o = in_write ? addr_q[OFF+IDX-1:0] : '0;
  assign sd.dc_wr_data_o = in_write ? data_q : '0;
  assign sd.dc_wr_bm_o   = in_write ? bm_q : '0;

  assign sd.bus_req_valid_o = (state_q == BUS_REQ);
  assign sd.bus_addr_o      = addr_q;
  assign sd.bus_data_o      = data_q;
  assign sd.bus_bm_o        = bm_q;
  assign sd.bus_io_o        = io_q;
endmodule
